// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bus between the fetch/decode/execute datapath and pipe_hazard_ctrl.
// Purely combinational signal bundle, no flow control of its own.
interface pipe_hazard_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] dec_rs1_addr_i;
    logic [REG_AW-1:0] dec_rs2_addr_i;
    logic [6:0]        ex_opcode_i;
    logic [REG_AW-1:0] ex_rd_addr_i;
    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              lsu_busy_i;
    logic              dbg_halt_req_i;

    logic              pc_stall_o;
    logic              pc_load_o;
    logic [XLEN-1:0]   pc_load_val_o;
    logic              dec_halt_o;
    logic              pipe_hold_o;
    logic              flush_o;
    logic              dbg_halted_o;
    logic [2:0]        state_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;

    modport master (
        output dec_rs1_addr_i, dec_rs2_addr_i, ex_opcode_i, ex_rd_addr_i,
               redirect_i, redirect_pc_i, lsu_busy_i, dbg_halt_req_i,
        input  pc_stall_o, pc_load_o, pc_load_val_o, dec_halt_o, pipe_hold_o,
               flush_o, dbg_halted_o, state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  dec_rs1_addr_i, dec_rs2_addr_i, ex_opcode_i, ex_rd_addr_i,
               redirect_i, redirect_pc_i, lsu_busy_i, dbg_halt_req_i,
        output pc_stall_o, pc_load_o, pc_load_val_o, dec_halt_o, pipe_hold_o,
               flush_o, dbg_halted_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RV32I pipeline sequencer: redirect flush, load-use bubble, LSU wait, debug drain. Mealy, 0-cycle response.
// Optional perf counters behind PIPE_CTRL_PERF_EN; holds/stalls are the backpressure it emits.
module pipe_hazard_ctrl #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        FLUSH    = 3'd1,
        WAIT_MEM = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            lu;
    logic [REG_AW-1:0] ex_rd;
    logic            pc_stall, pc_load, dec_halt, pipe_hold, flush, halted;
    logic [XLEN-1:0] pc_load_val;

    assign ex_rd = bus.ex_rd_addr_i;
    assign lu = (bus.ex_opcode_i == 7'b0000011) && (ex_rd != '0) &&
                ((ex_rd == bus.dec_rs1_addr_i) || (ex_rd == bus.dec_rs2_addr_i));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_stall    = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        dec_halt    = 1'b0;
        pipe_hold   = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                if (bus.redirect_i) begin
                    pc_load     = 1'b1;
                    pc_load_val = bus.redirect_pc_i;
                    dec_halt    = 1'b1;
                    flush       = 1'b1;
                    cnt_nxt     = 3'(FLUSH_CYCLES - 1);
                    state_nxt   = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                end else if (bus.lsu_busy_i) begin
                    pipe_hold = 1'b1;
                    pc_stall  = 1'b1;
                    state_nxt = WAIT_MEM;
                end else if (lu) begin
                    // One bubble suffices: next cycle execute holds rd=x0.
                    pc_stall = 1'b1;
                    dec_halt = 1'b1;
                end else if (bus.dbg_halt_req_i) begin
                    pc_stall  = 1'b1;
                    dec_halt  = 1'b1;
                    cnt_nxt   = 3'(DRAIN_CYCLES - 1);
                    state_nxt = DRAIN;
                end
            end
            FLUSH: begin
                // The redirect cycle already used one slot, so leave when the count reaches 0.
                dec_halt = 1'b1;
                flush    = 1'b1;
                cnt_nxt  = cnt - 3'd1;
                if (cnt_nxt == 3'd0) state_nxt = RUN;
            end
            WAIT_MEM: begin
                if (bus.lsu_busy_i) begin
                    pipe_hold = 1'b1;
                    pc_stall  = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                pc_stall = 1'b1;
                dec_halt = 1'b1;
                if (!bus.dbg_halt_req_i) begin
                    state_nxt = RUN;
                end else if (cnt == 3'd0) begin
                    state_nxt = HALTED;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            HALTED: begin
                pc_stall = 1'b1;
                dec_halt = 1'b1;
                halted   = 1'b1;
                if (!bus.dbg_halt_req_i) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Reset forces every output quiet regardless of the combinational terms.
    assign bus.pc_stall_o    = pc_stall  & ~reset_i;
    assign bus.pc_load_o     = pc_load   & ~reset_i;
    assign bus.pc_load_val_o = reset_i ? '0 : pc_load_val;
    assign bus.dec_halt_o    = dec_halt  & ~reset_i;
    assign bus.pipe_hold_o   = pipe_hold & ~reset_i;
    assign bus.flush_o       = flush     & ~reset_i;
    assign bus.dbg_halted_o  = halted    & ~reset_i;
    assign bus.state_o       = reset_i ? 3'd0 : state;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush)    flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = reset_i ? 32'd0 : stall_cnt;
    assign bus.flush_cnt_o = reset_i ? 32'd0 : flush_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
    assign bus.flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle stimulus rows push expected outputs, popped at negedge.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(32), .REG_AW(5)) bif ();

    pipe_hazard_ctrl #(
        .XLEN(32), .REG_AW(5), .FLUSH_CYCLES(2), .DRAIN_CYCLES(3)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bif)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        redir;
        logic [31:0] rpc;
        logic        busy;
        logic        dbg;
        logic        rst;
    } stim_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        stall;
        logic        load;
        logic [31:0] val;
        logic        dhalt;
        logic        hold;
        logic        flush;
        logic        halted;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rs1 = 5'd1;
        s.rs2 = 5'd2;
        s.op  = 7'h33;
        s.rd  = 5'd3;
        return s;
    endfunction

    function automatic obs_t mk(input logic [2:0] st, input logic stall, input logic load,
                                input logic [31:0] val, input logic dhalt, input logic hold,
                                input logic flush, input logic halted);
        obs_t o;
        o.st = st; o.stall = stall; o.load = load; o.val = val;
        o.dhalt = dhalt; o.hold = hold; o.flush = flush; o.halted = halted;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(bif.state_o, bif.pc_stall_o, bif.pc_load_o, bif.pc_load_val_o,
                  bif.dec_halt_o, bif.pipe_hold_o, bif.flush_o, bif.dbg_halted_o);
    endfunction

    task automatic apply(input stim_t s, input obs_t e);
        rst                 = s.rst;
        bif.dec_rs1_addr_i  = s.rs1;
        bif.dec_rs2_addr_i  = s.rs2;
        bif.ex_opcode_i     = s.op;
        bif.ex_rd_addr_i    = s.rd;
        bif.redirect_i      = s.redir;
        bif.redirect_pc_i   = s.rpc;
        bif.lsu_busy_i      = s.busy;
        bif.dbg_halt_req_i  = s.dbg;
        exp_q.push_back(e);
    endtask

    localparam obs_t Z = '0;

    task automatic test_reset();
        stim_t s[3];
        obs_t  e[3];
        obs_t  x, g;
        s[0] = idle(); s[0].rst = 1'b1; s[0].redir = 1'b1; s[0].rpc = 32'h80; e[0] = Z;
        s[1] = idle(); s[1].rst = 1'b1; s[1].busy = 1'b1; s[1].dbg = 1'b1;   e[1] = Z;
        s[2] = idle();                                                          e[2] = Z;
        for (int i = 0; i < 3; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL reset[%0d]: got %h want %h", i, g, x); end
            if (i < 2) begin
                n_cmp++;
                if (bif.stall_cnt_o !== 32'd0 || bif.flush_cnt_o !== 32'd0) begin
                    n_bad++;
                    $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", i, bif.stall_cnt_o, bif.flush_cnt_o);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[7];
        obs_t  e[7];
        obs_t  x, g;
        s[0] = idle(); s[0].rst = 1'b1; e[0] = Z;
        s[1] = idle(); s[1].op = 7'h03; s[1].rd = 5'd5; s[1].rs1 = 5'd5; e[1] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[2] = idle(); s[2].op = 7'h03; s[2].rd = 5'd0; s[2].rs1 = 5'd0; s[2].rs2 = 5'd0; e[2] = Z;
        s[3] = idle(); s[3].op = 7'h03; s[3].rd = 5'd7; s[3].rs2 = 5'd7; e[3] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[4] = idle(); s[4].op = 7'h03; s[4].rd = 5'd9; s[4].rs1 = 5'd9; e[4] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[5] = idle(); s[5].op = 7'h13; s[5].rd = 5'd5; s[5].rs1 = 5'd5; e[5] = Z;
        s[6] = idle(); s[6].op = 7'h03; s[6].rd = 5'd4; e[6] = Z;
        for (int i = 0; i < 7; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL load_use[%0d]: got %h want %h", i, g, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        stim_t s[5];
        obs_t  e[5];
        obs_t  x, g;
        logic [31:0] want;
        s[0] = idle(); s[0].rst = 1'b1; e[0] = Z;
        s[1] = idle(); s[1].redir = 1'b1; s[1].rpc = 32'h0000_0100; e[1] = mk(3'd0, 0, 1, 32'h100, 1, 0, 1, 0);
        s[2] = idle(); s[2].redir = 1'b1; s[2].rpc = 32'h0000_0200; e[2] = mk(3'd1, 0, 0, 0, 1, 0, 1, 0);
        s[3] = idle(); e[3] = Z;
        s[4] = idle(); s[4].redir = 1'b1; s[4].rpc = 32'hdead_beec; e[4] = mk(3'd0, 0, 1, 32'hdead_beec, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL redirect[%0d]: got %h want %h", i, g, x); end
            if (i == 3) begin
`ifdef PIPE_CTRL_PERF_EN
                want = 32'd2;
`else
                want = 32'd0;
`endif
                n_cmp++;
                if (bif.flush_cnt_o !== want) begin
                    n_bad++; $display("FAIL flush_cnt: got %0d want %0d", bif.flush_cnt_o, want);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lsu_wait();
        stim_t s[7];
        obs_t  e[7];
        obs_t  x, g;
        logic [31:0] want;
        s[0] = idle(); s[0].rst = 1'b1; e[0] = Z;
        s[1] = idle(); s[1].busy = 1'b1; e[1] = mk(3'd0, 1, 0, 0, 0, 1, 0, 0);
        s[2] = idle(); s[2].busy = 1'b1; e[2] = mk(3'd2, 1, 0, 0, 0, 1, 0, 0);
        s[3] = idle(); s[3].busy = 1'b1; s[3].redir = 1'b1; s[3].rpc = 32'h44; e[3] = mk(3'd2, 1, 0, 0, 0, 1, 0, 0);
        s[4] = idle(); s[4].busy = 1'b1; s[4].op = 7'h03; s[4].rd = 5'd1; e[4] = mk(3'd2, 1, 0, 0, 0, 1, 0, 0);
        s[5] = idle(); s[5].op = 7'h03; s[5].rd = 5'd1; e[5] = mk(3'd2, 0, 0, 0, 0, 0, 0, 0);
        s[6] = idle(); e[6] = Z;
        for (int i = 0; i < 7; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL lsu_wait[%0d]: got %h want %h", i, g, x); end
            if (i == 6) begin
`ifdef PIPE_CTRL_PERF_EN
                want = 32'd4;
`else
                want = 32'd0;
`endif
                n_cmp++;
                if (bif.stall_cnt_o !== want) begin
                    n_bad++; $display("FAIL stall_cnt: got %0d want %0d", bif.stall_cnt_o, want);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_debug_halt();
        stim_t s[11];
        obs_t  e[11];
        obs_t  x, g;
        obs_t  hlt;
        hlt = mk(3'd4, 1, 0, 0, 1, 0, 0, 1);
        s[0] = idle(); s[0].rst = 1'b1; e[0] = Z;
        s[1] = idle(); s[1].dbg = 1'b1; e[1] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[2] = idle(); s[2].dbg = 1'b1; e[2] = mk(3'd3, 1, 0, 0, 1, 0, 0, 0);
        s[3] = idle(); s[3].dbg = 1'b1; e[3] = mk(3'd3, 1, 0, 0, 1, 0, 0, 0);
        s[4] = idle(); s[4].dbg = 1'b1; e[4] = mk(3'd3, 1, 0, 0, 1, 0, 0, 0);
        s[5] = idle(); s[5].dbg = 1'b1; e[5] = hlt;
        s[6] = idle(); e[6] = hlt;
        s[7] = idle(); e[7] = Z;
        s[8] = idle(); s[8].dbg = 1'b1; e[8] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[9] = idle(); e[9] = mk(3'd3, 1, 0, 0, 1, 0, 0, 0);
        s[10] = idle(); e[10] = Z;
        for (int i = 0; i < 11; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL debug_halt[%0d]: got %h want %h", i, g, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        stim_t s[6];
        obs_t  e[6];
        obs_t  x, g;
        s[0] = idle(); s[0].rst = 1'b1; e[0] = Z;
        s[1] = idle(); s[1].redir = 1'b1; s[1].rpc = 32'h40; s[1].busy = 1'b1; s[1].dbg = 1'b1;
        s[1].op = 7'h03; s[1].rd = 5'd1;
        e[1] = mk(3'd0, 0, 1, 32'h40, 1, 0, 1, 0);
        s[2] = idle(); s[2].busy = 1'b1; e[2] = mk(3'd1, 0, 0, 0, 1, 0, 1, 0);
        s[3] = idle(); s[3].busy = 1'b1; e[3] = mk(3'd0, 1, 0, 0, 0, 1, 0, 0);
        s[4] = idle(); e[4] = mk(3'd2, 0, 0, 0, 0, 0, 0, 0);
        s[5] = idle(); e[5] = Z;
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL priority[%0d]: got %h want %h", i, g, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_t s[5];
        obs_t  e[5];
        obs_t  x, g;
        s[0] = idle(); s[0].dbg = 1'b1; e[0] = mk(3'd0, 1, 0, 0, 1, 0, 0, 0);
        s[1] = idle(); s[1].dbg = 1'b1; e[1] = mk(3'd3, 1, 0, 0, 1, 0, 0, 0);
        s[2] = idle(); s[2].dbg = 1'b1; s[2].rst = 1'b1; e[2] = Z;
        s[3] = idle(); e[3] = Z;
        s[4] = idle(); s[4].redir = 1'b1; s[4].rpc = 32'h10; e[4] = mk(3'd0, 0, 1, 32'h10, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = exp_q.pop_front(); g = observe(); n_cmp++;
            if (g !== x) begin n_bad++; $display("FAIL reset_drain[%0d]: got %h want %h", i, g, x); end
            if (i == 3) begin
                n_cmp++;
                if (bif.stall_cnt_o !== 32'd0 || bif.flush_cnt_o !== 32'd0) begin
                    n_bad++;
                    $display("FAIL reset_drain_cnt: got %0d/%0d want 0/0", bif.stall_cnt_o, bif.flush_cnt_o);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(idle(), Z);
        rst = 1'b1;
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_lsu_wait();
        test_debug_halt();
        test_priority();
        test_reset_mid_drain();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. Sits between fetch, decode and execute and decides each cycle whether the front end advances, holds, or squashes. It drives the decode stage `halt_i` bubble input (rd forced to x0), the PC hold and PC-load controls, and a global hold for load/store wait states. It also handles external debug halt requests with a pipeline drain.

## Interface
Parameters:
- `XLEN`, 32: data/PC width.
- `REG_AW`, 5: register address width.
- `FLUSH_CYCLES`, 2: wrong-path slots squashed after a redirect, counting the redirect cycle. Legal range 1..7.
- `DRAIN_CYCLES`, 3: cycles of bubbles before `dbg_halted_o` asserts. Legal range 1..7.

Ports. Clock is `clk_i`, reset is `reset_i`: one clock, reset synchronous and active-high.
- `clk_i` in 1: system clock.
- `reset_i` in 1: synchronous active-high reset.
- `dec_rs1_addr_i` in REG_AW: rs1 address of the instruction in decode.
- `dec_rs2_addr_i` in REG_AW: rs2 address of the instruction in decode.
- `ex_opcode_i` in 7: opcode of the instruction in execute.
- `ex_rd_addr_i` in REG_AW: rd of the instruction in execute.
- `redirect_i` in 1: taken branch or jump resolved in execute.
- `redirect_pc_i` in XLEN: target PC for the redirect.
- `lsu_busy_i` in 1: load/store unit not ready.
- `dbg_halt_req_i` in 1: level-sensitive external halt request.
- `pc_stall_o` out 1: hold the PC and fetch register.
- `pc_load_o` out 1: load the PC from `pc_load_val_o`.
- `pc_load_val_o` out XLEN: new PC value.
- `dec_halt_o` out 1: to decode `halt_i`; inserts a bubble.
- `pipe_hold_o` out 1: freeze the decode and execute stage registers.
- `flush_o` out 1: a squash is in progress.
- `dbg_halted_o` out 1: core is halted and drained.
- `state_o` out 3: FSM state, for debug.
- `stall_cnt_o` out 32: performance counter.
- `flush_cnt_o` out 32: performance counter.

## Operation
- FSM states and encodings: RUN=0, FLUSH=1, WAIT_MEM=2, DRAIN=3, HALTED=4.
- Load-use hazard `lu` = (`ex_opcode_i`==7'b0000011) && (`ex_rd_addr_i`!=0) && (`ex_rd_addr_i`==`dec_rs1_addr_i` || `ex_rd_addr_i`==`dec_rs2_addr_i`).
  - Both sources are compared for every format. This is conservative.
- RUN, priority order:
  1. `redirect_i`: `pc_load_o`=1, `pc_load_val_o`=`redirect_pc_i`, `dec_halt_o`=1, `flush_o`=1. Load the counter with FLUSH_CYCLES-1. Go to FLUSH, or stay in RUN if FLUSH_CYCLES==1.
  2. `lsu_busy_i`: `pipe_hold_o`=1, `pc_stall_o`=1. Go to WAIT_MEM.
  3. `lu`: `pc_stall_o`=1, `dec_halt_o`=1 this cycle only. The next cycle sees rd=x0 in execute, so no state change occurs.
  4. `dbg_halt_req_i`: `pc_stall_o`=1, `dec_halt_o`=1. Load the counter with DRAIN_CYCLES-1. Go to DRAIN.
- FLUSH:
  - Outputs: `dec_halt_o`=1, `flush_o`=1, `pc_stall_o`=0.
  - `redirect_i` is ignored because it comes from a wrong-path instruction.
  - Counter decrements each cycle; at 0, go to RUN.
- WAIT_MEM:
  - Outputs: `pipe_hold_o`=1, `pc_stall_o`=1.
  - `redirect_i` and `lu` are ignored.
  - When `lsu_busy_i`=0, drop the holds in the same cycle and go to RUN.
- DRAIN:
  - Outputs: `pc_stall_o`=1, `dec_halt_o`=1.
  - Counter decrements; at 0, go to HALTED.
  - If `dbg_halt_req_i` drops, return to RUN.
- HALTED:
  - Outputs: `pc_stall_o`=1, `dec_halt_o`=1, `dbg_halted_o`=1.
  - When `dbg_halt_req_i`=0, go to RUN with no bubble.
- Outputs not listed for a state are 0. `pc_load_val_o` is 0 whenever `pc_load_o`=0.

## Timing
- While `reset_i`=1, every output is 0 and `state_o`=RUN. This overrides combinational terms.
- Reset taken mid-FLUSH, WAIT_MEM, DRAIN or HALTED: at the next edge the state is RUN and the counters are 0.
- Redirect, load-use and stall responses are Mealy: asserted in the same cycle as the triggering input, 0-cycle latency.
- State changes take effect at the next rising edge.
- Redirect at cycle N with FLUSH_CYCLES=2: `dec_halt_o` is high at N and N+1, the state is RUN at N+2.
- Simultaneous `redirect_i` and `lsu_busy_i` in RUN: the redirect wins. The LSU condition is re-evaluated after the FLUSH state ends.
- `dbg_halted_o` rises exactly DRAIN_CYCLES+1 edges after `dbg_halt_req_i` is first sampled in RUN, provided no higher-priority event occurs.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments every non-reset cycle with `pc_stall_o`=1.
  - `flush_cnt_o` increments every cycle with `flush_o`=1.
  - Both wrap 0xFFFFFFFF→0 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Load-use: execute holds `lw x5` while decode has rs1=x5 → `pc_stall_o`=`dec_halt_o`=1 for exactly 1 cycle, `state_o`=0 throughout. With rd=x0 → no stall.
- Redirect: `redirect_i`=1, `redirect_pc_i`=0x0000_0100 → `pc_load_o`=1 with 0x100 the same cycle, `dec_halt_o` high 2 cycles. A second `redirect_i` during FLUSH produces no `pc_load_o`.
- LSU wait: `lsu_busy_i` high for 4 cycles → `pipe_hold_o`=`pc_stall_o`=1 for 4 cycles, then 0 in the cycle it drops. `stall_cnt_o`=4 with `PIPE_CTRL_PERF_EN`.
- Debug halt: hold `dbg_halt_req_i` → `dbg_halted_o`=1 four edges later. Release → RUN next edge, `pc_stall_o`=0.
- Priority: `redirect_i`, `lsu_busy_i` and `lu` together in RUN → only the redirect response; state FLUSH next edge.
- Reset mid-DRAIN: assert `reset_i` 1 cycle → all outputs 0, `state_o`=0, counters 0.
